// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU-sharing arbiter: sequencer states, ALU op codes
// and the captured command word.
package alu_share_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [1:0] OP_INC       = 2'b00;
   localparam logic [1:0] OP_ADD       = 2'b01;
   localparam logic [1:0] OP_SUB       = 2'b10;
   localparam logic [1:0] OP_ONE_MINUS = 2'b11;

   typedef struct packed {
      logic [1:0] op;
      logic [2:0] a;
      logic [2:0] b;
   } alu_cmd_t;

endpackage

// File: rtl/alu_share_arbiter_circuits.sv
// Shared 3-bit four-function ALU: A+1, A+B, B-A, 1-B.
// Combinational; carry is the raw adder carry-out (1 means no borrow on subtracts).
module circuits
   import alu_share_arbiter_pkg::*;
(
   input  logic [1:0] s,
   input  logic [2:0] a,
   input  logic [2:0] b,
   output logic [2:0] g,
   output logic       carry
);

   logic [3:0] sum;

   always_comb begin
      sum = 4'd0;
      case (s)
         OP_INC:  sum = {1'b0, a} + 4'd1;
         OP_ADD:  sum = {1'b0, a} + {1'b0, b};
         OP_SUB:  sum = {1'b0, b} + {1'b0, ~a} + 4'd1;
         default: sum = {1'b0, ~b} + 4'd2;
      endcase
   end

   assign g     = sum[2:0];
   assign carry = sum[3];

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request after ptr, wrapping modulo N_REQ.
// Purely combinational; emits a one-hot grant and the matching binary index.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  idx
);

   // Walk the search order backwards so the nearest candidate after ptr wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         if (req[(int'(ptr) + k) % N_REQ]) begin
            grant = '0;
            grant[(int'(ptr) + k) % N_REQ] = 1'b1;
            idx = ID_W'((int'(ptr) + k) % N_REQ);
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among N_REQ requesters with round-robin grant, one op in flight.
// Latency: rsp_valid rises 2 edges after the grant cycle; at least 3 cycles per op.
// Backpressure: result held until rsp_ready; no grants while busy.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [2*N_REQ-1:0] req_op,
   input  logic [3*N_REQ-1:0] req_a,
   input  logic [3*N_REQ-1:0] req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [ID_W-1:0]    rsp_id,
   output logic [2:0]         rsp_g,
   output logic               rsp_carry,
   output logic               busy
);

   state_t           state, state_nxt;
   logic [ID_W-1:0]  rr_ptr, cap_id, win_idx;
   logic [N_REQ-1:0] win_grant;
   alu_cmd_t         cmd;
   logic [2:0]       alu_g;
   logic             alu_carry;
   logic             grant_go;

   rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (win_grant),
      .idx   (win_idx)
   );

   // The ALU only ever sees the capture registers, never live requester inputs.
   circuits u_alu (
      .s     (cmd.op),
      .a     (cmd.a),
      .b     (cmd.b),
      .g     (alu_g),
      .carry (alu_carry)
   );

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      grant_go  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rst && |req_valid) begin
               req_ready = win_grant;
               grant_go  = 1'b1;
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         rr_ptr    <= ID_W'(N_REQ - 1);
         cmd       <= '0;
         cap_id    <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_g     <= 3'd0;
         rsp_carry <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant_go) begin
            cmd.op <= req_op[2*int'(win_idx) +: 2];
            cmd.a  <= req_a[3*int'(win_idx) +: 3];
            cmd.b  <= req_b[3*int'(win_idx) +: 3];
            cap_id <= win_idx;
            rr_ptr <= win_idx;
         end
         if (state == ST_EXEC) begin
            rsp_g     <= alu_g;
            rsp_carry <= alu_carry;
            rsp_id    <= cap_id;
            rsp_valid <= 1'b1;
         end
         if (state == ST_RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised + directed bench for alu_share_arbiter against a transaction-level model.
module tb_alu_share_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [2*N-1:0] req_op = '0;
   logic [3*N-1:0] req_a = '0;
   logic [3*N-1:0] req_b = '0;
   logic           rsp_valid;
   logic           rsp_ready = 1'b0;
   logic [1:0]     rsp_id;
   logic [2:0]     rsp_g;
   logic           rsp_carry;
   logic           busy;

   always #5 clk = ~clk;

   alu_share_arbiter #(.N_REQ(N), .ID_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_g     (rsp_g),
      .rsp_carry (rsp_carry),
      .busy      (busy)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Arithmetic view of the ALU: modulo-8 result, carry as "overflowed" / "no borrow".
   function automatic void ref_alu(input int op, input int a, input int b,
                                   output int g, output int c);
      int r;
      case (op)
         0: begin r = a + 1; g = r % 8; c = (r >= 8) ? 1 : 0; end
         1: begin r = a + b; g = r % 8; c = (r >= 8) ? 1 : 0; end
         2: begin g = (b - a + 8) % 8; c = (b >= a) ? 1 : 0; end
         default: begin g = (1 - b + 8) % 8; c = (b <= 1) ? 1 : 0; end
      endcase
   endfunction

   // Transaction-level model: one outstanding op, round-robin pointer, response 2 edges after grant.
   bit       outstanding = 0;
   int       age = 0;
   int       mptr = N - 1;
   int       exp_id, exp_g, exp_c;
   int       cyc = 0;
   int       w;
   logic [N-1:0] last_hs = '0;
   int       grant_log[$];
   int       grant_cyc[$];

   always @(negedge clk) begin
      cyc++;
      last_hs = '0;
      if (rst) begin
         chk("ready_in_rst", int'(req_ready), 0);
         outstanding = 0;
         mptr = N - 1;
      end else if (!outstanding) begin
         w = -1;
         for (int k = 1; k <= N; k++)
            if (w < 0 && req_valid[(mptr + k) % N]) w = (mptr + k) % N;
         chk("ready_idle", int'(req_ready), (w < 0) ? 0 : (1 << w));
         chk("busy_idle", int'(busy), 0);
         chk("rsp_valid_idle", int'(rsp_valid), 0);
         if (w >= 0) begin
            outstanding = 1;
            age = 0;
            mptr = w;
            exp_id = w;
            ref_alu(int'(req_op[2*w +: 2]), int'(req_a[3*w +: 3]), int'(req_b[3*w +: 3]),
                    exp_g, exp_c);
            last_hs[w] = 1'b1;
            grant_log.push_back(w);
            grant_cyc.push_back(cyc);
         end
      end else begin
         age++;
         chk("ready_busy", int'(req_ready), 0);
         chk("busy_flag", int'(busy), 1);
         chk("rsp_valid", int'(rsp_valid), (age >= 2) ? 1 : 0);
         if (age >= 2) begin
            chk("rsp_id", int'(rsp_id), exp_id);
            chk("rsp_g", int'(rsp_g), exp_g);
            chk("rsp_carry", int'(rsp_carry), exp_c);
            if (rsp_ready) outstanding = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (last_hs[i]) req_valid[i] = 1'b0;
   endtask

   task automatic raise(input int i, input int op, input int a, input int b);
      req_valid[i]        = 1'b1;
      req_op[2*i +: 2]    = 2'(op);
      req_a[3*i +: 3]     = 3'(a);
      req_b[3*i +: 3]     = 3'(b);
   endtask

   task automatic run_one(input int i, input int op, input int a, input int b,
                          input int eg, input int ec);
      int n;
      n = 0;
      rsp_ready = 1'b1;
      raise(i, op, a, b);
      while (!rsp_valid && n < 30) begin
         tick();
         n++;
      end
      chk("dir_latency", n, 2);
      chk("dir_id", int'(rsp_id), i);
      chk("dir_g", int'(rsp_g), eg);
      chk("dir_carry", int'(rsp_carry), ec);
      tick();
   endtask

   task automatic drain();
      int n;
      n = 0;
      rsp_ready = 1'b1;
      while ((req_valid != '0 || busy) && n < 200) begin
         tick();
         n++;
      end
      chk("drain_bound", (n < 200) ? 1 : 0, 1);
   endtask

   int exp_ord[5] = '{0, 1, 2, 3, 0};
   int g0, n;

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_rsp_valid", int'(rsp_valid), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_rsp_id", int'(rsp_id), 0);
      chk("reset_rsp_g", int'(rsp_g), 0);
      chk("reset_rsp_carry", int'(rsp_carry), 0);

      // Directed ALU cases
      run_one(0, 0, 7, 0, 0, 1);
      run_one(1, 1, 3, 5, 0, 1);
      run_one(1, 2, 3, 5, 2, 1);
      run_one(2, 3, 0, 2, 7, 0);
      run_one(2, 3, 0, 0, 1, 1);

      // All requesters continuously valid after reset: strict rotation, 3 cycles apart
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rsp_ready = 1'b1;
      g0 = grant_log.size();
      for (int c = 0; c < 16; c++) begin
         for (int i = 0; i < N; i++)
            if (!req_valid[i]) raise(i, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7));
         tick();
      end
      drain();
      chk("rotation_count", (grant_log.size() - g0 >= 5) ? 1 : 0, 1);
      if (grant_log.size() - g0 >= 5) begin
         for (int k = 0; k < 5; k++) chk("rotation_order", grant_log[g0 + k], exp_ord[k]);
         for (int k = 1; k < 5; k++) chk("rotation_spacing", grant_cyc[g0 + k] - grant_cyc[g0 + k - 1], 3);
      end

      // Response backpressure: hold rsp_ready low in RESP
      rsp_ready = 1'b0;
      raise(3, 1, 6, 5);
      raise(1, 2, 5, 1);
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      repeat (5) tick();
      chk("stall_held_valid", int'(rsp_valid), 1);
      rsp_ready = 1'b1;
      tick();
      chk("stall_released", int'(rsp_valid), 0);
      drain();

      // Reset during EXEC discards the op and restores the pointer
      raise(2, 1, 1, 1);
      n = 0;
      while (req_valid[2] && n < 20) begin
         tick();
         n++;
      end
      chk("exec_busy", int'(busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", int'(rsp_valid), 0);
      chk("mid_rst_busy", int'(busy), 0);
      g0 = grant_log.size();
      raise(0, 0, 2, 0);
      raise(3, 0, 4, 0);
      drain();
      chk("post_rst_grants", (grant_log.size() > g0) ? 1 : 0, 1);
      if (grant_log.size() > g0) chk("post_rst_first", grant_log[g0], 0);

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && $urandom_range(0, 2) == 0)
               raise(i, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7));
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
